// File: rtl/serial_link_arbiter_pkg.sv
// Shared types and sizing for the serial link arbiter.
// Latency: n/a (types, constants and a sizing helper only).
// Backpressure: n/a.
package serial_link_arbiter_pkg;

  // Item field widths; the default item is a full header + payload + address.
  localparam int HDR_SZ      = 8;
  localparam int PL_SZ       = 32;
  localparam int ADDR_SZ     = 8;
  localparam int ITEM_W_DFLT = HDR_SZ + PL_SZ + ADDR_SZ;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // line low, waiting for a request and a free receiver
    SEND = 2'd1,  // shifting data bits, then the guard bit
    HOLD = 2'd2   // one quiet cycle so the receiver's busy can settle
  } link_state_t;

  // Bit counter width able to hold the value w (the guard-bit index).
  function automatic int cnt_width(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_link_arbiter_rr_arbiter.sv
// Round-robin pick among requesters, starting just after the last grant.
// Latency: purely combinational.
// Backpressure: none; the parent decides when the pick is used.
//
// Ports:
//   req        in   N_REQ  pending requests
//   last_grant in   IDX_W  index granted most recently (search starts at +1)
//   grant      out  N_REQ  one-hot winner (all zero when nothing is pending)
//   grant_idx  out  IDX_W  binary index of the winner
//   grant_vld  out  1      a winner exists
module serial_link_arbiter_rr_arbiter
  import serial_link_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [IDX_W-1:0] cand;

  // Walk k = 1..N_REQ past the last grant so the last winner is checked last.
  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % N_REQ);
      if (!grant_vld && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_vld   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_link_arbiter.sv
// Shares one serial line among N_REQ requesters; frames = start 1, data LSB first, guard 0.
// Latency: req sampled at edge E0 -> start bit and ack pulse in the cycle after E0; frame ITEM_W+2 cycles, plus 1 quiet cycle.
// Backpressure: no launch while channel_busy is high in IDLE; requesters hold req/item until their one-cycle ack.
//
// Ports:
//   clk, reset    clock; synchronous active-high reset
//   req, items    per-requester valid and item (item i at [i*ITEM_W +: ITEM_W])
//   ack           one-cycle pulse to the requester whose item was latched
//   channel_busy  receiver busy; blocks new frames only
//   serial_out    registered serial line, low when idle
//   busy          high while a frame (or its quiet cycle) is in progress
//   grant_id      index of the most recently granted requester
module serial_link_arbiter
  import serial_link_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ITEM_W = ITEM_W_DFLT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ITEM_W-1:0]   items,
  output logic [N_REQ-1:0]          ack,
  input  logic                      channel_busy,
  output logic                      serial_out,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = cnt_width(ITEM_W);

  link_state_t       state, state_nxt;
  logic [ITEM_W-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]  bitcnt, bitcnt_nxt;
  logic              serial_nxt;
  logic [N_REQ-1:0]  ack_nxt;
  logic [IDX_W-1:0]  grant_nxt;

  logic [N_REQ-1:0]  win_grant;
  logic [IDX_W-1:0]  win_idx;
  logic              win_vld;

  serial_link_arbiter_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req        (req),
    .last_grant (grant_id),
    .grant      (win_grant),
    .grant_idx  (win_idx),
    .grant_vld  (win_vld)
  );

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
    serial_nxt = 1'b0;
    ack_nxt    = '0;
    grant_nxt  = grant_id;
    case (state)
      IDLE: begin
        if (win_vld && !channel_busy) begin
          shreg_nxt  = items[int'(win_idx)*ITEM_W +: ITEM_W];
          serial_nxt = 1'b1;
          ack_nxt    = win_grant;
          grant_nxt  = win_idx;
          bitcnt_nxt = '0;
          state_nxt  = SEND;
        end
      end
      SEND: begin
        if (bitcnt == CNT_W'(ITEM_W)) begin
          // Guard bit: the line drops to 0 and stays there through HOLD.
          serial_nxt = 1'b0;
          bitcnt_nxt = '0;
          state_nxt  = HOLD;
        end else begin
          serial_nxt = shreg[0];
          shreg_nxt  = shreg >> 1;
          bitcnt_nxt = bitcnt + CNT_W'(1);
        end
      end
      HOLD: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      serial_out <= 1'b0;
      ack        <= '0;
      shreg      <= '0;
      bitcnt     <= '0;
      grant_id   <= IDX_W'(N_REQ - 1);  // requester 0 wins first
    end else begin
      state      <= state_nxt;
      serial_out <= serial_nxt;
      ack        <= ack_nxt;
      shreg      <= shreg_nxt;
      bitcnt     <= bitcnt_nxt;
      grant_id   <= grant_nxt;
    end
  end

endmodule

// File: tb/tb_serial_link_arbiter.sv
// Testbench for serial_link_arbiter with N_REQ=4, ITEM_W=8.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// A line decoder rebuilds frames from serial_out for comparison with expected items.
module tb_serial_link_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] items;
  logic [N-1:0]   ack;
  logic           channel_busy;
  logic           serial_out;
  logic           busy;
  logic [1:0]     grant_id;

  always #5 clk = ~clk;

  serial_link_arbiter #(.N_REQ(N), .ITEM_W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .items        (items),
    .ack          (ack),
    .channel_busy (channel_busy),
    .serial_out   (serial_out),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int mdl_last;

  always @(posedge clk) cyc <= cyc + 1;

  // Snapshot of what the DUT sampled at the latest posedge.
  logic [N-1:0]   req_snap;
  logic [N*W-1:0] items_snap;
  logic           cb_snap;
  always @(posedge clk) begin
    req_snap   <= req;
    items_snap <= items;
    cb_snap    <= channel_busy;
  end

  // Line decoder: start 1, W data bits LSB first, guard 0.
  logic [W-1:0] rx_q[$];
  int           guard_err  = 0;
  int           onehot_err = 0;
  bit           in_frame   = 1'b0;
  int           bit_i      = 0;
  logic [W-1:0] cur;
  always @(negedge clk) begin
    if (reset) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (serial_out === 1'b1) begin
        in_frame = 1'b1;
        bit_i    = 0;
        cur      = '0;
      end
    end else if (bit_i < W) begin
      cur[bit_i] = serial_out;
      bit_i++;
    end else begin
      if (serial_out !== 1'b0) guard_err++;
      rx_q.push_back(cur);
      in_frame = 1'b0;
    end
    if (!reset && $countones(ack) > 1) onehot_err++;
  end

  logic [W-1:0] exp_q[$];

  // Round-robin rule: first pending requester after the last grant, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] a);
    for (int i = 0; i < N; i++)
      if (a[i]) return i;
    return -1;
  endfunction

  task automatic wait_ack(input int budget, output int idx);
    idx = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        idx = oh_idx(ack);
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    channel_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mdl_last = N - 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0;
    items = '0;
    channel_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (serial_out !== 1'b0) $display("FAIL reset_serial: got %b want 0", serial_out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (ack !== 4'b0000) $display("FAIL reset_ack: got %b want 0000", ack); else n_pass++;
    n_checks++; if (grant_id !== 2'd3) $display("FAIL reset_grant_id: got %0d want 3", grant_id); else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mdl_last = N - 1;
  endtask

  task automatic test_single_frame();
    logic [W-1:0] it;
    logic [10:0]  seq, want;
    int           ack_cnt, busy_cnt;
    do_reset();
    it = 8'hA5;
    items[0 +: W] = it;
    req = 4'b0001;
    want[0] = 1'b1;
    for (int b = 0; b < W; b++) want[1+b] = it[b];
    want[9] = 1'b0;
    want[10] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (ack !== 4'b0001) $display("FAIL single_ack_latency: got %b want 0001", ack); else n_pass++;
    seq[0] = serial_out;
    ack_cnt = (ack != '0) ? 1 : 0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) req = '0;
      @(negedge clk);
      seq[c] = serial_out;
      if (ack != '0) ack_cnt++;
      if (c <= 9 && busy === 1'b1) busy_cnt++;
    end
    n_checks++; if (seq !== want) $display("FAIL single_serial_seq: got %b want %b (bit0 first)", seq, want); else n_pass++;
    n_checks++; if (ack_cnt !== 1) $display("FAIL single_ack_cycles: got %0d want 1", ack_cnt); else n_pass++;
    n_checks++; if (busy_cnt !== 10) $display("FAIL single_busy_frame: got %0d want 10", busy_cnt); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || serial_out !== 1'b0) $display("FAIL single_idle_after: busy %b line %b want 0 0", busy, serial_out); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int idx, prev_cyc, rx_base, want;
    do_reset();
    rx_base = rx_q.size();
    exp_q.delete();
    for (int i = 0; i < N; i++) items[i*W +: W] = W'($urandom);
    req = 4'b1111;
    prev_cyc = -1;
    for (int f = 0; f < 8; f++) begin
      wait_ack(30, idx);
      want = rr_pick(4'b1111, mdl_last);
      n_checks++; if (idx !== want) $display("FAIL b2b_grant[%0d]: got %0d want %0d", f, idx, want); else n_pass++;
      if (idx < 0) break;
      mdl_last = want;
      exp_q.push_back(items[idx*W +: W]);
      if (prev_cyc >= 0) begin
        n_checks++; if (cyc - prev_cyc !== 11) $display("FAIL b2b_spacing[%0d]: got %0d want 11", f, cyc - prev_cyc); else n_pass++;
      end
      prev_cyc = cyc;
      @(posedge clk);
      #1;
      items[idx*W +: W] = W'($urandom);
    end
    req = '0;
    repeat (14) @(negedge clk);
    n_checks++; if (rx_q.size() - rx_base !== exp_q.size()) $display("FAIL b2b_frame_count: got %0d want %0d", rx_q.size() - rx_base, exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && rx_base + i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[rx_base+i] !== exp_q[i]) $display("FAIL b2b_frame[%0d]: got %h want %h", i, rx_q[rx_base+i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_channel_busy();
    int ack_seen, line_seen, rx_base;
    logic [W-1:0] it;
    do_reset();
    rx_base = rx_q.size();
    it = W'($urandom);
    items[2*W +: W] = it;
    channel_busy = 1'b1;
    req = 4'b0100;
    ack_seen = 0;
    line_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack != '0) ack_seen++;
      if (serial_out !== 1'b0) line_seen++;
    end
    n_checks++; if (ack_seen !== 0) $display("FAIL cbusy_no_ack: got %0d acks want 0", ack_seen); else n_pass++;
    n_checks++; if (line_seen !== 0) $display("FAIL cbusy_line_low: got %0d high cycles want 0", line_seen); else n_pass++;
    @(posedge clk);
    #1;
    channel_busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (ack !== 4'b0100 || serial_out !== 1'b1) $display("FAIL cbusy_release: ack %b line %b want 0100 1", ack, serial_out); else n_pass++;
    // Receiver goes busy mid-frame: the frame must still complete intact.
    @(posedge clk);
    #1;
    req = '0;
    channel_busy = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++; if (rx_q.size() - rx_base !== 1) $display("FAIL cbusy_frame_count: got %0d want 1", rx_q.size() - rx_base); else n_pass++;
    if (rx_q.size() > rx_base) begin
      n_checks++; if (rx_q[rx_base] !== it) $display("FAIL cbusy_frame: got %h want %h", rx_q[rx_base], it); else n_pass++;
    end
    // Busy drop and a fresh request in the same cycle launch at that edge.
    @(posedge clk);
    #1;
    channel_busy = 1'b0;
    items[1*W +: W] = W'($urandom);
    req = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (ack !== 4'b0010) $display("FAIL cbusy_same_cycle: got %b want 0010", ack); else n_pass++;
    @(posedge clk);
    #1;
    req = '0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    int idx, rx_base;
    logic [W-1:0] it;
    do_reset();
    items[0 +: W] = W'($urandom);
    req = 4'b0001;
    wait_ack(5, idx);
    n_checks++; if (idx !== 0) $display("FAIL midrst_first: got %0d want 0", idx); else n_pass++;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    req = '0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (serial_out !== 1'b0) $display("FAIL midrst_serial: got %b want 0", serial_out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (ack !== 4'b0000) $display("FAIL midrst_ack: got %b want 0000", ack); else n_pass++;
    n_checks++; if (grant_id !== 2'd3) $display("FAIL midrst_grant_id: got %0d want 3", grant_id); else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mdl_last = N - 1;
    rx_base = rx_q.size();
    it = W'($urandom);
    items[1*W +: W] = it;
    req = 4'b0010;
    wait_ack(5, idx);
    n_checks++; if (idx !== 1) $display("FAIL midrst_winner: got %0d want 1", idx); else n_pass++;
    @(posedge clk);
    #1;
    req = '0;
    repeat (12) @(negedge clk);
    n_checks++; if (rx_q.size() - rx_base !== 1) $display("FAIL midrst_frame_count: got %0d want 1", rx_q.size() - rx_base); else n_pass++;
    if (rx_q.size() > rx_base) begin
      n_checks++; if (rx_q[rx_base] !== it) $display("FAIL midrst_frame: got %h want %h", rx_q[rx_base], it); else n_pass++;
    end
  endtask

  task automatic test_pair_fairness();
    int idx, want, rx_base;
    do_reset();
    rx_base = rx_q.size();
    exp_q.delete();
    for (int i = 0; i < N; i++) items[i*W +: W] = W'($urandom);
    req = 4'b1010;
    for (int f = 0; f < 6; f++) begin
      wait_ack(30, idx);
      want = (f % 2 == 0) ? 1 : 3;
      n_checks++; if (idx !== want) $display("FAIL pair_grant[%0d]: got %0d want %0d", f, idx, want); else n_pass++;
      if (idx < 0) break;
      mdl_last = want;
      exp_q.push_back(items[idx*W +: W]);
      @(posedge clk);
      #1;
      items[idx*W +: W] = W'($urandom);
    end
    req = '0;
    repeat (14) @(negedge clk);
    n_checks++; if (rx_q.size() - rx_base !== exp_q.size()) $display("FAIL pair_frame_count: got %0d want %0d", rx_q.size() - rx_base, exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && rx_base + i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[rx_base+i] !== exp_q[i]) $display("FAIL pair_frame[%0d]: got %h want %h", i, rx_q[rx_base+i], exp_q[i]); else n_pass++;
    end
  endtask

  // Random requesters and receiver busy; the model decides, per cycle, whether a
  // launch must happen, who wins, and which item goes on the line.
  task automatic test_random();
    int  pend, last_ack, want, rx_base, bad;
    bit  eligible;
    do_reset();
    rx_base = rx_q.size();
    exp_q.delete();
    pend = -1;
    last_ack = -100;
    bad = 0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      if (pend >= 0) begin
        if ($urandom_range(1, 0) == 1) items[pend*W +: W] = W'($urandom);
        else req[pend] = 1'b0;
        pend = -1;
      end
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(7, 0) == 0) begin
          items[i*W +: W] = W'($urandom);
          req[i] = 1'b1;
        end
      end
      channel_busy = ($urandom_range(9, 0) < 3);
      @(negedge clk);
      eligible = (c - last_ack >= 11) && (req_snap != '0) && !cb_snap;
      n_checks++;
      if ((ack != '0) !== eligible) begin
        $display("FAIL rand_launch@%0d: ack %b want launch %b", c, ack, eligible);
        bad++;
      end else n_pass++;
      if (ack != '0) begin
        want = rr_pick(req_snap, mdl_last);
        n_checks++; if (oh_idx(ack) !== want) $display("FAIL rand_grant@%0d: got %0d want %0d", c, oh_idx(ack), want); else n_pass++;
        if (want >= 0) begin
          mdl_last = want;
          exp_q.push_back(items_snap[want*W +: W]);
        end
        pend = oh_idx(ack);
        last_ack = c;
      end
      if (bad > 20) break;
    end
    req = '0;
    channel_busy = 1'b0;
    repeat (14) @(negedge clk);
    n_checks++; if (rx_q.size() - rx_base !== exp_q.size()) $display("FAIL rand_frame_count: got %0d want %0d", rx_q.size() - rx_base, exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && rx_base + i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[rx_base+i] !== exp_q[i]) $display("FAIL rand_frame[%0d]: got %h want %h", i, rx_q[rx_base+i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (guard_err !== 0) $display("FAIL guard_bits: got %0d bad guards want 0", guard_err); else n_pass++;
    n_checks++; if (onehot_err !== 0) $display("FAIL ack_onehot: got %0d multi-ack cycles want 0", onehot_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_channel_busy();
    test_reset_midframe();
    test_pair_fairness();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
